// File: rtl/result_display_driver_if.sv
// Result bus between calculator_top and the display driver: capture strobe,
// conversion handshake and the converted result.
interface result_display_driver_if;
  logic [15:0] value;
  logic        load;
  logic        busy;
  logic        done;
  logic        negative;
  logic [19:0] bcd;

  // Calculator side drives value/load and watches the handshake.
  modport master (
    output value, load,
    input  busy, done, negative, bcd
  );

  // Display driver side.
  modport slave (
    input  value, load,
    output busy, done, negative, bcd
  );
endinterface

// File: rtl/result_display_driver.sv
// Captures a signed 16-bit result, converts it to sign + 5 BCD digits with a
// sequential shift-add-3, and scans a 6-position active-low 7-segment display.
module result_display_driver #(
  parameter int unsigned SCAN_DIV = 1000,
  parameter bit          BLANK_LZ = 1'b1
) (
  input  logic                    clk,
  input  logic                    RST,
  result_display_driver_if.slave  bus,
  output logic [6:0]              seg,
  output logic [5:0]              an
);

  localparam int unsigned CntW = $clog2(SCAN_DIV);
  localparam logic [CntW-1:0] CntMax = CntW'(SCAN_DIV - 1);

  localparam logic [6:0] SegBlank = 7'b1111111;
  localparam logic [6:0] SegMinus = 7'b0111111;

  typedef enum logic [1:0] {StIdle, StConvert, StDone} state_e;

  state_e      state_q, state_d;
  logic [3:0]  iter_q, iter_d;
  logic [15:0] mag_q, mag_d;
  logic [19:0] work_q, work_d;
  logic        sign_q, sign_d;
  logic [19:0] bcd_q, bcd_d;
  logic        neg_q, neg_d;

  logic [CntW-1:0] cnt_q, cnt_d;
  logic [2:0]      idx_q, idx_d;
  logic [6:0]      seg_q, seg_d;
  logic [5:0]      an_q, an_d;

  logic [19:0] adj;
  logic [35:0] shifted;

  function automatic logic [6:0] digit_seg(input logic [3:0] d);
    logic [6:0] s;
    case (d)
      4'd0:    s = 7'b1000000;
      4'd1:    s = 7'b1111001;
      4'd2:    s = 7'b0100100;
      4'd3:    s = 7'b0110000;
      4'd4:    s = 7'b0011001;
      4'd5:    s = 7'b0010010;
      4'd6:    s = 7'b0000010;
      4'd7:    s = 7'b1111000;
      4'd8:    s = 7'b0000000;
      4'd9:    s = 7'b0010000;
      default: s = SegBlank;
    endcase
    return s;
  endfunction

  // Conversion FSM next state: capture, 16 shift-add-3 iterations, result publish.
  always_comb begin
    state_d = state_q;
    iter_d  = iter_q;
    mag_d   = mag_q;
    work_d  = work_q;
    sign_d  = sign_q;
    bcd_d   = bcd_q;
    neg_d   = neg_q;

    for (int k = 0; k < 5; k++) begin
      adj[4*k +: 4] = (work_q[4*k +: 4] >= 4'd5) ? work_q[4*k +: 4] + 4'd3 : work_q[4*k +: 4];
    end
    shifted = {adj, mag_q} << 1;

    unique case (state_q)
      StIdle: begin
        if (bus.load) begin
          state_d = StConvert;
          sign_d  = bus.value[15];
          // 16-bit unsigned magnitude holds 32768 for the -32768 case.
          mag_d   = bus.value[15] ? (~bus.value + 16'd1) : bus.value;
          work_d  = '0;
          iter_d  = '0;
        end
      end
      StConvert: begin
        work_d = shifted[35:16];
        mag_d  = shifted[15:0];
        iter_d = iter_q + 4'd1;
        if (iter_q == 4'd15) begin
          state_d = StDone;
          bcd_d   = shifted[35:16];
          neg_d   = sign_q;
        end
      end
      StDone:  state_d = StIdle;
      default: state_d = StIdle;
    endcase
  end

  // Conversion state registers.
  always_ff @(posedge clk) begin
    if (RST) begin
      state_q <= StIdle;
      iter_q  <= '0;
      mag_q   <= '0;
      work_q  <= '0;
      sign_q  <= 1'b0;
      bcd_q   <= '0;
      neg_q   <= 1'b0;
    end else begin
      state_q <= state_d;
      iter_q  <= iter_d;
      mag_q   <= mag_d;
      work_q  <= work_d;
      sign_q  <= sign_d;
      bcd_q   <= bcd_d;
      neg_q   <= neg_d;
    end
  end

  // Scan timing and pattern for the next enabled position.
  always_comb begin
    logic [4:0] hide;
    logic       zero_above;
    logic [3:0] cur_dig;

    cnt_d = cnt_q + 1'b1;
    idx_d = idx_q;
    if (cnt_q == CntMax) begin
      cnt_d = '0;
      idx_d = (idx_q == 3'd5) ? 3'd0 : idx_q + 3'd1;
    end

    // A position is blank when it and every higher digit are zero.
    hide       = '0;
    zero_above = 1'b1;
    for (int k = 4; k >= 1; k--) begin
      zero_above = zero_above && (bcd_q[4*k +: 4] == 4'd0);
      hide[k]    = BLANK_LZ && zero_above;
    end

    cur_dig = bcd_q[3:0];
    unique case (idx_d)
      3'd0:    cur_dig = bcd_q[3:0];
      3'd1:    cur_dig = bcd_q[7:4];
      3'd2:    cur_dig = bcd_q[11:8];
      3'd3:    cur_dig = bcd_q[15:12];
      3'd4:    cur_dig = bcd_q[19:16];
      default: cur_dig = 4'd0;
    endcase

    if (idx_d == 3'd5) begin
      seg_d = neg_q ? SegMinus : SegBlank;
    end else if (hide[idx_d]) begin
      seg_d = SegBlank;
    end else begin
      seg_d = digit_seg(cur_dig);
    end

    an_d = ~(6'b000001 << idx_d);
  end

  // Scan registers; seg and an move together on the same edge.
  always_ff @(posedge clk) begin
    if (RST) begin
      cnt_q <= '0;
      idx_q <= '0;
      seg_q <= 7'b1000000;
      an_q  <= 6'b111110;
    end else begin
      cnt_q <= cnt_d;
      idx_q <= idx_d;
      seg_q <= seg_d;
      an_q  <= an_d;
    end
  end

  assign bus.busy     = (state_q == StConvert);
  assign bus.done     = (state_q == StDone);
  assign bus.negative = neg_q;
  assign bus.bcd      = bcd_q;
  assign seg          = seg_q;
  assign an           = an_q;

endmodule

// File: doc/result_display_driver.md
Name: result_display_driver

Overview:
- Sits directly downstream of calculator_top.
- Captures the signed 16-bit display_output word when complete asserts, converts it sequentially to sign plus 5-digit BCD (shift-add-3), and drives a time-multiplexed 6-position active-low seven-segment display.
- Position 5 holds the sign; positions 4..0 hold the digits.
- Provides a load/busy/done handshake so the calculator never needs to hold its result stable.

Parameters:
- SCAN_DIV, 1000, clk cycles each digit position stays enabled before advancing (minimum 2).
- BLANK_LZ, 1, 1 = blank leading zeros in positions 4..1; 0 = show all digits.

Ports:
- clk  input  1  system clock, rising edge.
- RST  input  1  synchronous reset, active-high.
- value  input  16  two's-complement result from calculator_top.display_output.
- load  input  1  one-cycle capture strobe (tied to complete).
- busy  output  1  conversion in progress.
- done  output  1  one-cycle pulse; new digits valid from this cycle.
- negative  output  1  registered sign of last converted value.
- bcd  output  20  five BCD digits {d4,d3,d2,d1,d0}.
- seg  output  7  {g,f,e,d,c,b,a}, active-low.
- an  output  6  digit enables, one-hot active-low; an[5] = sign position.

Behaviour:
- Reset, sampled on the clk edge while RST=1:
  - busy=0, done=0, negative=0, bcd=0, state=IDLE.
  - Scan index=0, scan counter=0.
  - an=6'b111110, seg=7'b1000000 ('0').
- RST wins over every other event and aborts a conversion in progress. Outputs take their reset values on the next edge.
- States:
  - IDLE -> CONVERT on an edge with load=1. That edge latches the magnitude and the sign.
    - Magnitude = value[15] ? -value : value, computed at 17 bits, so -32768 -> 32768.
    - Sign = value[15].
    - Iteration counter and shift register are cleared on the same edge.
  - CONVERT: 16 iterations, one per cycle. Each cycle, add 3 to every BCD nibble >= 5, then shift {bcd_work, mag} left by 1. busy=1 throughout.
  - After the 16th iteration -> DONE. For exactly one cycle: done=1, busy=0. bcd and negative update on entry to DONE.
  - DONE -> IDLE unconditionally.
- Latency: load sampled at edge N -> busy high for cycles N+1..N+16 -> done high in cycle N+17.
- load while busy or in DONE: ignored, no queueing.
- bcd, negative and the display hold the previous result throughout a conversion. No intermediate values are visible.
- Negative zero cannot occur. Value 0 gives negative=0 and bcd=0.
- Scan:
  - The counter counts 0..SCAN_DIV-1 and wraps. On wrap, the index advances 0->1->...->5->0.
  - an = ~(6'b1 << index).
  - The scan runs continuously, independent of conversion state.
- seg per index:
  - Index 0: always shows d0.
  - Index 1..4: shows d[index]. If BLANK_LZ=1 and d[index] and all higher digits are 0, shows blank (7'b1111111).
  - Index 5: shows '-' (7'b0111111) if negative, else blank.
- Digit codes:
  - 0=1000000, 1=1111001, 2=0100100, 3=0110000, 4=0011001
  - 5=0010010, 6=0000010, 7=1111000, 8=0000000, 9=0010000
- seg and an are registered. They change on the same edge, so a digit position never shows another position's pattern.

Test Plan:
- value=1575, pulse load: busy high 16 cycles, done pulses at cycle 17, bcd=20'h01575, negative=0.
- value=-9 (16'hFFF7): bcd=20'h00009, negative=1. Over one full scan with SCAN_DIV=4:
  - an[0] with seg=0010000 ('9').
  - an[1..4] with seg=1111111.
  - an[5] with seg=0111111.
- value=-32768 (16'h8000) -> bcd=20'h32768, negative=1. value=32767 -> bcd=20'h32767, negative=0. value=0 -> bcd=0, negative=0, index 0 shows '0'.
- load 12, then re-pulse load with 99 at cycle 5 of the conversion: second load ignored, bcd=20'h00012, exactly one done pulse. Then load 99 after done: bcd=20'h00099.
- Assert RST at cycle 8 of a conversion of 1575:
  - Next cycle: busy=0, done=0, bcd=0, an=111110, seg=1000000.
  - No done pulse follows.
  - A subsequent load of 7 yields bcd=20'h00007.
- BLANK_LZ=0, value=12: index 2..4 show '0' (1000000), index 1 '1', index 0 '2'. an cycles through every position once per 6*SCAN_DIV cycles.
